// File: rtl/key_event_conditioner_pkg.sv
// Shared types and default tuning constants for the per-key event conditioner.
// Imported by the debounce stage and the repeat FSM top.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  localparam int KEY_DEBOUNCE_CYCLES = 4;
  localparam int KEY_REPEAT_DELAY    = 16;
  localparam int KEY_REPEAT_RATE     = 4;
  localparam int KEY_CNT_W           = 8;

endpackage

// File: rtl/key_event_conditioner_if.sv
// Key input and event outputs of one conditioned player key.
// slave = conditioner side, master = consumer/stimulus side.
interface key_event_conditioner_if;

  logic key_sync;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic step_pulse;

  modport slave (
    input  key_sync,
    output key_level,
    output press_pulse,
    output release_pulse,
    output step_pulse
  );

  modport master (
    output key_sync,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  step_pulse
  );

endinterface

// File: rtl/key_event_conditioner_debounce.sv
// Mismatch-count debouncer: the level flips after DEBOUNCE_CYCLES consecutive
// differing samples. rise/fall are asserted during the cycle whose edge flips it.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int CNT_W           = KEY_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic key_sync,
  output logic key_level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             flip;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    flip    = 1'b0;
    // Any sample matching the current level restarts the count.
    if (key_sync != level_q) begin
      if (cnt_q == CNT_LAST) begin
        flip    = 1'b1;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign key_level = level_q;
  assign rise      = flip & ~level_q;
  assign fall      = flip &  level_q;

endmodule

// File: rtl/key_event_conditioner.sv
// Per-key conditioner: debounced level, press/release pulses and a step pulse
// that auto-repeats while the key is held. All outputs come straight from flops.
module key_event_conditioner
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY,
  parameter int REPEAT_RATE     = KEY_REPEAT_RATE,
  parameter int CNT_W           = KEY_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  key_event_conditioner_if.slave  kif
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic lvl;
  logic lvl_rise;
  logic lvl_fall;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .key_sync  (kif.key_sync),
    .key_level (lvl),
    .rise      (lvl_rise),
    .fall      (lvl_fall)
  );

  rep_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             step_q, step_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    step_d    = 1'b0;
    // A falling level overrides any repeat step scheduled for the same cycle.
    if (lvl_fall) begin
      state_d   = IDLE;
      cnt_d     = '0;
      release_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (lvl_rise) begin
            press_d = 1'b1;
            step_d  = 1'b1;
            state_d = DELAY;
            cnt_d   = '0;
          end
        end
        DELAY: begin
          if (cnt_q == DELAY_LAST) begin
            step_d  = 1'b1;
            state_d = REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          // Reloads each period, so an arbitrarily long hold never wraps.
          if (cnt_q == RATE_LAST) begin
            step_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
    end
  end

  assign kif.key_level     = lvl;
  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = release_q;
  assign kif.step_pulse    = step_q;

endmodule

// File: tb/tb_key_event_conditioner.sv
// Scoreboard bench: a timing model in terms of debounce samples and hold age
// pushes expected outputs per edge; they are popped and compared after the edge.
module tb_key_event_conditioner;

  localparam int DEB  = 4;
  localparam int DLY  = 16;
  localparam int RATE = 4;

  logic clk = 1'b0;
  logic reset;

  key_event_conditioner_if kif();

  key_event_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (DLY),
    .REPEAT_RATE     (RATE),
    .CNT_W           (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // expected {level, press, release, step}
  logic [3:0] exp_q[$];

  int m_mism  = 0;
  int m_age   = 0;
  bit m_level = 1'b0;

  int sc_cyc    = 0;
  int press_at  = -1;
  int rel_at    = -1;
  int n_press   = 0;
  int n_rel     = 0;
  int n_step    = 0;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, sc_cyc, obs, exp_v);
    end
  endtask

  task automatic scen_start();
    sc_cyc   = 0;
    press_at = -1;
    rel_at   = -1;
    n_press  = 0;
    n_rel    = 0;
    n_step   = 0;
  endtask

  task automatic tick();
    bit flip, e_press, e_rel, e_step;
    logic [3:0] e;
    flip = 1'b0; e_press = 1'b0; e_rel = 1'b0; e_step = 1'b0;
    if (reset) begin
      m_level = 1'b0;
      m_mism  = 0;
      m_age   = 0;
    end else begin
      if (kif.key_sync != m_level) begin
        m_mism++;
        if (m_mism == DEB) begin
          m_level = ~m_level;
          m_mism  = 0;
          flip    = 1'b1;
        end
      end else begin
        m_mism = 0;
      end
      e_press = flip && m_level;
      e_rel   = flip && !m_level;
      if (e_press) m_age = 0;
      else if (m_level) m_age++;
      e_step = e_press || (m_level && m_age >= DLY && ((m_age - DLY) % RATE) == 0);
    end
    exp_q.push_back({m_level, e_press, e_rel, e_step});
    @(posedge clk);
    #1;
    sc_cyc++;
    e = exp_q.pop_front();
    check_val("key_level", int'(kif.key_level),     int'(e[3]));
    check_val("press",     int'(kif.press_pulse),   int'(e[2]));
    check_val("release",   int'(kif.release_pulse), int'(e[1]));
    check_val("step",      int'(kif.step_pulse),    int'(e[0]));
    if (kif.press_pulse === 1'b1) begin n_press++; press_at = sc_cyc; end
    if (kif.release_pulse === 1'b1) begin n_rel++; rel_at = sc_cyc; end
    if (kif.step_pulse === 1'b1) n_step++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset        = 1'b1;
    kif.key_sync = 1'b1;
    @(negedge clk);

    // reset held two cycles with the key pressed
    scen_start();
    ticks(2);
    check_val("rst_press_cnt", n_press, 0);

    reset        = 1'b0;
    kif.key_sync = 1'b0;
    ticks(3);

    // glitch of 3 samples is swallowed
    scen_start();
    kif.key_sync = 1'b1;
    ticks(3);
    kif.key_sync = 1'b0;
    ticks(8);
    check_val("glitch_press_cnt", n_press, 0);
    check_val("glitch_level", int'(kif.key_level), 0);

    // hold to t0+19 then release: steps at t0, t0+16, t0+20
    scen_start();
    kif.key_sync = 1'b1;
    ticks(4);
    check_val("press_latency", press_at, 4);
    ticks(19);
    kif.key_sync = 1'b0;
    ticks(4);
    check_val("rel_latency", rel_at, 4 + 19 + 4);
    ticks(10);
    check_val("hold19_steps", n_step, 3);
    check_val("hold19_rel_cnt", n_rel, 1);

    // release debounced exactly on the t0+20 repeat slot
    scen_start();
    kif.key_sync = 1'b1;
    ticks(20);
    kif.key_sync = 1'b0;
    ticks(4);
    check_val("coinc_rel_at", rel_at, 4 + 20);
    check_val("coinc_steps", n_step, 2);
    ticks(6);

    // long hold: steps at t0, +16, +20, ..., +40
    scen_start();
    kif.key_sync = 1'b1;
    ticks(4 + 40);
    check_val("long_steps", n_step, 8);
    kif.key_sync = 1'b0;
    ticks(8);

    // reset mid-hold: no release, fresh press after reset
    scen_start();
    kif.key_sync = 1'b1;
    ticks(4 + 10);
    reset = 1'b1;
    tick();
    check_val("midrst_rel_cnt", n_rel, 0);
    check_val("midrst_level", int'(kif.key_level), 0);
    reset = 1'b0;
    scen_start();
    ticks(4);
    check_val("post_rst_press_at", press_at, 4);
    kif.key_sync = 1'b0;
    ticks(8);

    // random runs of mixed lengths
    scen_start();
    for (int r = 0; r < 60; r++) begin
      kif.key_sync = 1'($urandom_range(0, 1));
      ticks(int'($urandom_range(1, 25)));
    end
    kif.key_sync = 1'b0;
    ticks(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
